// File: rtl/sin_rom_pkg.sv
// Shared widths and the in-flight read tag used by the sine ROM arbiter.
package sin_rom_pkg;
  localparam int SIN_ADDR_W   = 10;
  localparam int SIN_DATA_W   = 16;
  localparam int SIN_ROM_LAT  = 3;
  localparam int SIN_ID_MAX_W = 3;

  typedef struct packed {
    logic                    valid;
    logic [SIN_ID_MAX_W-1:0] id;
  } sin_tag_t;
endpackage

// File: rtl/sin_rom_arb_rr.sv
// Combinational round-robin pick: first set request scanning upward from ptr+1 with wrap.
module rr_arb #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]  o_idx,
  output logic             o_any
);
  logic [ID_W-1:0] w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_j = ID_W'((int'(i_ptr) + k) % N_REQ);
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end
endmodule

// File: rtl/sin_rom_arb.sv
// Round-robin sharing of one sine ROM between N_REQ requesters; responses are
// tagged with the requester ID through a tag pipeline matched to the ROM latency.
module sin_rom_arb
  import sin_rom_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ROM_LAT = SIN_ROM_LAT,
  parameter int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                          clka,
  input  logic                          rstn,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ*SIN_ADDR_W-1:0]   phase,
  output logic [N_REQ-1:0]              ack,
  output logic [SIN_ADDR_W-1:0]         rom_addra,
  input  logic [SIN_DATA_W-1:0]         rom_douta,
  output logic                          rsp_valid,
  output logic [ID_W-1:0]               rsp_id,
  output logic [SIN_DATA_W-1:0]         rsp_data
);
  logic [ID_W-1:0]       r_ptr;
  logic [SIN_ADDR_W-1:0] r_addra;
  sin_tag_t              r_tag [ROM_LAT+1];

  logic [N_REQ-1:0]      w_gnt;
  logic [ID_W-1:0]       w_idx;
  logic                  w_any;
  logic [SIN_ADDR_W-1:0] w_phase;
  logic                  w_unused_id;

  rr_arb #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  always_comb begin
    w_phase = '0;
    for (int i = 0; i < N_REQ; i++)
      if (w_idx == ID_W'(i)) w_phase = phase[i*SIN_ADDR_W +: SIN_ADDR_W];
  end

  // Stage 0 rides alongside rom_addra; stages 1..ROM_LAT track the ROM's own registers.
  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      r_ptr   <= ID_W'(N_REQ - 1);
      r_addra <= '0;
      for (int s = 0; s <= ROM_LAT; s++) r_tag[s] <= '0;
    end else begin
      if (w_any) begin
        r_addra <= w_phase;
        r_ptr   <= w_idx;
      end
      r_tag[0].valid <= w_any;
      r_tag[0].id    <= SIN_ID_MAX_W'(w_idx);
      for (int s = 1; s <= ROM_LAT; s++) r_tag[s] <= r_tag[s-1];
    end
  end

  assign ack         = rstn ? w_gnt : '0;
  assign rom_addra   = r_addra;
  assign rsp_valid   = r_tag[ROM_LAT].valid;
  assign rsp_id      = r_tag[ROM_LAT].id[ID_W-1:0];
  assign rsp_data    = rom_douta;
  // Tag id is sized for the largest N_REQ; upper bits are dead for smaller arbiters.
  assign w_unused_id = &{1'b0, r_tag[ROM_LAT].id};
endmodule

// File: tb/tb_sin_rom_arb.sv
// Scoreboard bench for sin_rom_arb with a 3-stage ROM model driven from rom_addra.
module tb_sin_rom_arb;
  localparam int N   = 4;
  localparam int LAT = 3;
  localparam int IDW = 2;

  logic            clka = 1'b0;
  logic            rstn = 1'b0;
  logic [N-1:0]    req  = '0;
  logic [N*10-1:0] phase = '0;
  logic [N-1:0]    ack;
  logic [9:0]      rom_addra;
  logic [15:0]     rom_douta;
  logic            rsp_valid;
  logic [IDW-1:0]  rsp_id;
  logic [15:0]     rsp_data;

  always #5 clka = ~clka;

  sin_rom_arb #(.N_REQ(N), .ROM_LAT(LAT)) dut (
    .clka      (clka),
    .rstn      (rstn),
    .req       (req),
    .phase     (phase),
    .ack       (ack),
    .rom_addra (rom_addra),
    .rom_douta (rom_douta),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  function automatic logic [15:0] rom_fn(input logic [9:0] p);
    case (p)
      10'h000: rom_fn = 16'h0000;
      10'h001: rom_fn = 16'h00C9;
      10'h0FF: rom_fn = 16'h7FFF;
      10'h100: rom_fn = 16'h7FFF;
      10'h200: rom_fn = 16'hFFFF;
      10'h201: rom_fn = 16'hFF36;
      default: rom_fn = {p[5:0], p} ^ 16'hA5A5;
    endcase
  endfunction

  logic [15:0] rom_p1, rom_p2;
  always @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      rom_p1 <= '0; rom_p2 <= '0; rom_douta <= '0;
    end else begin
      rom_p1 <= rom_fn(rom_addra); rom_p2 <= rom_p1; rom_douta <= rom_p2;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          id;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t         sbq[$];
  int           gnt_log[$];
  int           cyc = 0;
  int           mptr = N - 1;
  int           rsp_cnt = 0;
  int           mw;
  int           mj;
  logic [N-1:0] eack;
  exp_t         e;

  always @(posedge clka) cyc <= cyc + 1;

  always @(negedge clka) begin
    if (!rstn) begin
      chk("ack_in_rst", ack, 0);
      chk("vld_in_rst", rsp_valid, 0);
      mptr = N - 1;
      sbq.delete();
    end else begin
      mw = -1;
      eack = '0;
      for (int k = 1; k <= N; k++) begin
        mj = (mptr + k) % N;
        if (mw < 0 && req[mj]) mw = mj;
      end
      if (mw >= 0) eack[mw] = 1'b1;
      chk("ack", ack, eack);
      if (mw >= 0) begin
        sbq.push_back('{mw, rom_fn(phase[mw*10 +: 10]), cyc + 1 + LAT});
        gnt_log.push_back(mw);
        mptr = mw;
      end
      if (rsp_valid) begin
        rsp_cnt++;
        if (sbq.size() == 0) chk("spurious_rsp", rsp_valid, 0);
        else begin
          e = sbq.pop_front();
          chk("rsp_id", rsp_id, e.id);
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clka);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clka); #2;
    rstn = 1'b0;
    req  = '0;
    step(2);
    rstn = 1'b1;
  endtask

  task automatic chk_log(input string tag, input int exp_q[$]);
    chk({tag, "_len"}, gnt_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < gnt_log.size(); i++)
      chk(tag, gnt_log[i], exp_q[i]);
  endtask

  int base_cnt;

  initial begin
    repeat (3) @(negedge clka);
    chk("addr_rst", rom_addra, 0);
    chk("vld_rst", rsp_valid, 0);
    chk("id_rst", rsp_id, 0);
    step(1);
    rstn = 1'b1;

    // single read, phase 0x001
    gnt_log.delete();
    phase[9:0] = 10'h001;
    req = 4'b0001;
    step(1);
    req = '0;
    step(6);
    chk_log("g_single", '{0});

    // all four requesters continuously
    do_reset();
    gnt_log.delete();
    phase = {10'h201, 10'h100, 10'h0FF, 10'h000};
    req = 4'b1111;
    step(8);
    req = '0;
    step(6);
    chk_log("g_all", '{0, 1, 2, 3, 0, 1, 2, 3});

    // only 2 and 3
    do_reset();
    gnt_log.delete();
    req = 4'b1100;
    step(6);
    req = '0;
    step(6);
    chk_log("g_23", '{2, 3, 2, 3, 2, 3});

    // single 0x200 from requester 1, then idle
    gnt_log.delete();
    base_cnt = rsp_cnt;
    phase[19:10] = 10'h200;
    req = 4'b0010;
    step(1);
    req = '0;
    step(10);
    @(negedge clka);
    chk("addr_hold", rom_addra, 10'h200);
    chk("one_rsp", rsp_cnt - base_cnt, 1);
    chk_log("g_200", '{1});
    step(1);

    // reset with three reads in flight, requests still asserted
    gnt_log.delete();
    req = 4'b1111;
    step(3);
    #1;
    rstn = 1'b0;
    #1;
    chk("vld_at_rst", rsp_valid, 0);
    step(2);
    rstn = 1'b1;
    req  = '0;
    gnt_log.delete();
    base_cnt = rsp_cnt;
    step(6);
    chk("no_rsp_after_rst", rsp_cnt - base_cnt, 0);
    req = 4'b0011;
    step(1);
    req = 4'b0010;
    step(1);
    req = '0;
    step(6);
    chk_log("g_post_rst", '{0, 1});
    chk("rsp_post_rst", rsp_cnt - base_cnt, 2);

    // requester 1 cancels before being acked
    do_reset();
    gnt_log.delete();
    req = 4'b0011;
    step(1);
    req = 4'b0100;
    step(1);
    req = '0;
    step(6);
    chk_log("g_drop", '{0, 2});

    chk("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sin_rom_arb.md
# sin_rom_arb

Round-robin arbiter that shares one quarter-wave sine ROM (10-bit phase in, 16-bit sample out, fixed 3-cycle read latency) between `N_REQ` independent requesters, such as DDS channels, I/Q generators or test-tone sources. Each cycle it grants at most one request and drives the ROM address from a register. It tracks in-flight reads with a tag pipeline aligned to the ROM latency, then returns each sample tagged with the requester ID. It sits between the phase generators and the single `sin_rom` instance in the FPGA user logic.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `ROM_LAT`, 3: ROM read latency in clocks, from `addra` valid to `douta` valid.
- `ID_W`, `$clog2(N_REQ)`: requester ID width (derived, minimum 1).
- `clka` input, 1 bit: clock, rising edge.
- `rstn` input, 1 bit: reset, asynchronous, active-low.
- `req` input, `N_REQ` bits: per-requester read request, level, held until acked.
- `phase` input, `N_REQ*10` bits: packed phase words; requester i uses `[10*i+9:10*i]`, stable while `req[i]` is high.
- `ack` output, `N_REQ` bits: one-hot, combinational; grant in the current cycle.
- `rom_addra` output, 10 bits: registered ROM address.
- `rom_douta` input, 16 bits: ROM data.
- `rsp_valid` output, 1 bit: sample valid, single-cycle pulse.
- `rsp_id` output, `ID_W` bits: requester ID for `rsp_data`.
- `rsp_data` output, 16 bits: sample; equals `rom_douta` in the `rsp_valid` cycle.

## Operation
- Grant rule: in each cycle with any `req` bit set, exactly one `ack` bit is high.
  - The winner is the first set `req` bit, scanning upward (with wrap) from `ptr+1`.
  - `ptr` holds the index of the last granted requester.
- On the clock edge that ends a grant cycle for winner w:
  - `rom_addra` <= `phase[w]`.
  - `ptr` <= w.
  - Tag stage 0 <= {valid=1, id=w}.
- No request: `ack`=0; `rom_addra` holds its value; tag stage 0 <= valid=0.
- Tag pipeline: `ROM_LAT` stages of {valid, id} shift every cycle. The last stage drives `rsp_valid` and `rsp_id` directly.
- `rsp_data` is a wire from `rom_douta`. There is no extra register.
- Requesters must not change `phase` until they see `ack`. After `ack` they may present the next phase in the next cycle.
- Fairness: a requester holding `req` high is granted within `N_REQ` cycles.
- Throughput: one grant per cycle, sustained with no bubbles.
- The arbiter does not interpret ROM data. Quadrant folding and sign inversion are done by the ROM.

## Timing
- Reset values (asynchronous, while `rstn`=0):
  - `rom_addra`=0, `rsp_valid`=0, `rsp_id`=0.
  - All tag valids = 0.
  - `ptr`=`N_REQ-1`, so requester 0 has first priority.
  - `ack` is forced to 0 while `rstn`=0.
- Latency: an `ack` in cycle t gives `rom_addra` in cycle t+1 and `rsp_valid` with data in cycle t+1+`ROM_LAT` (t+4 by default).
- Back-to-back grants return back-to-back responses in grant order.
- Reset mid-operation: all in-flight tags are discarded. No `rsp_valid` appears after reset until a new grant plus 4 cycles.
- The ROM shares `rstn`, so its pipeline clears in step with the tags.
- Simultaneous requests from every requester: grants rotate strictly, e.g. 0,1,2,3,0,… from reset.
- A requester that drops `req` without being acked is ignored. Dropping `req` is legal; it cancels the request.

## Structure
- Shared package `sin_rom_pkg`:
  - `SIN_ADDR_W`=10, `SIN_DATA_W`=16, `SIN_ROM_LAT`=3.
  - Typedef `sin_tag_t` {valid, id}.
- Sub-module `rr_arb`: combinational round-robin pick, with inputs req and ptr and outputs one-hot grant and index.
  - The pointer register stays in `sin_rom_arb`.
- The tag pipeline is an inline shift register of `sin_tag_t`, sized by `ROM_LAT`.

## Test plan
- After reset, `req[0]`=1 with phase 0x001: `ack[0]` in cycle t, then `rsp_valid` at t+4 with id 0 and data 0x00C9.
- All four requesters request continuously with phases 0x000, 0x0FF, 0x100, 0x201:
  - Grants follow 0,1,2,3,0,…
  - Responses return 0x0000, 0x7FFF, 0x7FFF, 0xFF36, each with the matching id, one per cycle.
- Only `req[2]` and `req[3]` active: grants alternate 2,3,2,3, with no grant to idle requesters and no response bubbles.
- Phase 0x200 from requester 1 then idle for 10 cycles:
  - One response, 0xFFFF with id 1.
  - `rsp_valid` low otherwise.
  - `rom_addra` holds 0x200.
- Reset asserted with 3 reads in flight: `rsp_valid`=0 immediately and stays 0 after release until a new grant plus 4 cycles; `ptr` returns to favour requester 0.
- Requester drops `req` before being acked: no `ack` and no response for it; the other requesters' ordering is unaffected.
